// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller arbitrating instruction fetch and load/store traffic
//
// Purpose:
//   Single owner of the 8-bit RAM/IO port. Accepts one request at a time from
//   the instruction fetch unit (always 4 bytes) or the load/store buffer
//   (1/2/4 bytes), with the load/store buffer winning ties. Each access is
//   split into byte transfers. A one-cycle done pulse returns the assembled
//   little-endian result. A ROB flush aborts reads. Stores always complete.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rdy                 global ready; low freezes every register
//   rob_clear           flush; aborts fetch/load in flight, blocks acceptance
//   io_buffer_full      IO write buffer full; holds off IO-region stores
//   mem_din/mem_dout    RAM read byte / RAM write byte
//   mem_a, mem_wr       RAM byte address, 1 = write
//   if_to_mc_*          fetch request (enable, pc)
//   mc_to_if_*          fetch done pulse and instruction word
//   lsb_to_mc_*         load/store request (enable, wr, addr, len, data)
//   mc_to_lsb_*         load/store done pulse and zero-extended load data

module mem_ctrl #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_HI_BITS = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rob_clear,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              if_to_mc_enable,
  input  logic [ADDR_W-1:0] if_to_mc_pc,
  output logic              mc_to_if_done,
  output logic [31:0]       mc_to_if_result,
  input  logic              lsb_to_mc_enable,
  input  logic              lsb_to_mc_wr,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [1:0]        lsb_to_mc_len,
  input  logic [31:0]       lsb_to_mc_data,
  output logic              mc_to_lsb_done,
  output logic [31:0]       mc_to_lsb_result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IFETCH,
    S_LOAD,
    S_STORE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;        // byte edges completed since acceptance
  logic [2:0]        len_q, len_d;        // access size in bytes: 1, 2 or 4
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;      // latched store data
  logic [31:0]       rbuf_q, rbuf_d;      // read assembly buffer
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d;
  logic              lsb_done_q, lsb_done_d;
  logic [31:0]       if_result_q, if_result_d;
  logic [31:0]       lsb_result_q, lsb_result_d;

  logic [2:0]        k;
  logic              last;
  logic [31:0]       rbuf_next;
  logic [2:0]        lsb_n;
  logic              lsb_ok;
  logic              can_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      data_q       <= '0;
      rbuf_q       <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_result_q  <= '0;
      lsb_result_q <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      data_q       <= data_d;
      rbuf_q       <= rbuf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_result_q  <= if_result_d;
      lsb_result_q <= lsb_result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    data_d       = data_q;
    rbuf_d       = rbuf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    if_result_d  = if_result_q;
    lsb_result_d = lsb_result_q;

    // k is the index of the edge being taken; byte k-1 arrives on mem_din now
    k    = cnt_q + 3'd1;
    last = (k == len_q);
    rbuf_next = rbuf_q;
    rbuf_next[8*cnt_q[1:0] +: 8] = mem_din;

    case (lsb_to_mc_len)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase

    // IO-region stores wait while the IO write buffer is full
    lsb_ok = lsb_to_mc_enable &&
             !(lsb_to_mc_wr && (lsb_to_mc_addr[17:16] == IO_HI_BITS) && io_buffer_full);
    // The done-cycle cooldown keeps a still-high enable from being re-accepted
    can_accept = !rob_clear && !if_done_q && !lsb_done_q;

    case (state_q)
      S_IDLE: begin
        if (can_accept) begin
          if (lsb_ok) begin
            base_d  = lsb_to_mc_addr;
            len_d   = lsb_n;
            data_d  = lsb_to_mc_data;
            cnt_d   = '0;
            mem_a_d = lsb_to_mc_addr;
            if (lsb_to_mc_wr) begin
              state_d    = S_STORE;
              mem_dout_d = lsb_to_mc_data[7:0];
              mem_wr_d   = 1'b1;
            end else begin
              state_d  = S_LOAD;
              mem_wr_d = 1'b0;
              rbuf_d   = '0;
            end
          end else if (if_to_mc_enable) begin
            state_d  = S_IFETCH;
            base_d   = if_to_mc_pc;
            len_d    = 3'd4;
            cnt_d    = '0;
            mem_a_d  = if_to_mc_pc;
            mem_wr_d = 1'b0;
            rbuf_d   = '0;
          end
        end
      end

      S_IFETCH, S_LOAD: begin
        if (rob_clear) begin
          state_d = S_IDLE;
          mem_a_d = '0;
          cnt_d   = '0;
        end else begin
          rbuf_d = rbuf_next;
          cnt_d  = k;
          if (last) begin
            state_d = S_IDLE;
            mem_a_d = '0;
            cnt_d   = '0;
            if (state_q == S_IFETCH) begin
              if_done_d   = 1'b1;
              if_result_d = rbuf_next;
            end else begin
              lsb_done_d   = 1'b1;
              lsb_result_d = rbuf_next;
            end
          end else begin
            mem_a_d = base_q + ADDR_W'(k);
          end
        end
      end

      S_STORE: begin
        // A committed store ignores rob_clear and always runs to completion
        cnt_d = k;
        if (last) begin
          state_d    = S_IDLE;
          mem_wr_d   = 1'b0;
          mem_a_d    = '0;
          mem_dout_d = '0;
          cnt_d      = '0;
          lsb_done_d = 1'b1;
        end else begin
          mem_a_d    = base_q + ADDR_W'(k);
          mem_dout_d = data_q[8*k[1:0] +: 8];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_a            = mem_a_q;
  assign mem_dout         = mem_dout_q;
  assign mem_wr           = mem_wr_q;
  assign mc_to_if_done    = if_done_q;
  assign mc_to_if_result  = if_result_q;
  assign mc_to_lsb_done   = lsb_done_q;
  assign mc_to_lsb_result = lsb_result_q;

endmodule
